// File: rtl/edge_window_dma.sv
// -----------------------------------------------------------------------------
// edge_window_dma
//   Bus-master frame engine for the edge-detection datapath. It reads an
//   IMG_WIDTH x IMG_HEIGHT image from word-addressed memory in raster order and
//   builds 3x3 neighbourhoods from two line buffers plus a 3x3 column shift
//   register. Each window goes to the filter core, and each filter result is
//   written back to memory.
//
//   Optional feature macro: BORDER_FILL_EN
//     undefined : output is (H-2) x (W-2) results, row stride W, at wr_base.
//     defined   : output is full size. Results are written at their centre
//                 positions, then the frame border is filled with FILL.
//
// Ports
//   clk, n_rst           clock; asynchronous active-low reset
//   start, stop          frame start pulse; abort request
//   rd_base, wr_base     image base addresses, sampled on start
//   hreq/haddr/hwrite    bus request, address, direction (1 = write)
//   hwdata/hrdata        bus write/read data; pixel in [PIX_W-1:0]
//   hready               slave completion strobe
//   win_valid/win_data   3x3 window to filter; slot 3i+j = (r-2+i, c-2+j)
//   win_ready            filter accepts window
//   res_valid/res_data   filter result
//   res_ready            engine accepts result
//   busy, done           frame in progress; frame completed (held)
// -----------------------------------------------------------------------------
module edge_window_dma #(
   parameter int               IMG_WIDTH  = 428,
   parameter int               IMG_HEIGHT = 428,
   parameter int               PIX_W      = 24,
   parameter int               ADDR_W     = 32,
   parameter logic [PIX_W-1:0] FILL       = PIX_W'(24'hFFFFFF)
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic [ADDR_W-1:0]    rd_base,
   input  logic [ADDR_W-1:0]    wr_base,
   output logic                 hreq,
   output logic [ADDR_W-1:0]    haddr,
   output logic                 hwrite,
   output logic [31:0]          hwdata,
   input  logic [31:0]          hrdata,
   input  logic                 hready,
   output logic                 win_valid,
   output logic [9*PIX_W-1:0]   win_data,
   input  logic                 win_ready,
   input  logic                 res_valid,
   input  logic [PIX_W-1:0]     res_data,
   output logic                 res_ready,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0]     C_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0]     R_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0]     C_TWO  = CW'(2);
   localparam logic [RW-1:0]     R_TWO  = RW'(2);
`ifdef BORDER_FILL_EN
   localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_WIDTH);
   // centre (r-1, c-1) at full-size position
   localparam logic [ADDR_W-1:0] WR_OFS = ADDR_W'(IMG_WIDTH + 1);
`else
   // centre (r-1, c-1) stored at (r-2, c-2) of the cropped output
   localparam logic [ADDR_W-1:0] WR_OFS = ADDR_W'(2 * IMG_WIDTH + 2);
`endif

   typedef enum logic [3:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WIN,
      RES,
      WR_REQ,
      WR_WAIT,
`ifdef BORDER_FILL_EN
      BORDER,
`endif
      ABORT
   } state_t;

   state_t                     state, state_d;
   logic [RW-1:0]              r, r_d;
   logic [CW-1:0]              c, c_d;
   // linear pixel index r*IMG_WIDTH + c, kept alongside r/c to avoid a multiply
   logic [ADDR_W-1:0]          pix, pix_d;
   logic [ADDR_W-1:0]          rd_base_q, rd_base_d;
   logic [ADDR_W-1:0]          wr_base_q, wr_base_d;
   logic [PIX_W-1:0]           res_q, res_d;
   logic                       hreq_d, hwrite_d, win_valid_d, res_ready_d, busy_d, done_d;
   logic [ADDR_W-1:0]          haddr_d;
   logic [31:0]                hwdata_d;
   logic                       rd_fire;
   logic                       adv;
   logic [PIX_W-1:0]           pix_in;
   logic [8:0][PIX_W-1:0]      win_q;
   logic [PIX_W-1:0]           lb1 [IMG_WIDTH];
   logic [PIX_W-1:0]           lb2 [IMG_WIDTH];
   logic                       unused_hrdata;
`ifdef BORDER_FILL_EN
   logic [RW-1:0]              br, br_d;
   logic [CW-1:0]              bc, bc_d;
   logic [ADDR_W-1:0]          bidx, bidx_d;
`endif

   assign pix_in        = hrdata[PIX_W-1:0];
   assign unused_hrdata = ^hrdata;
   assign win_data      = win_q;

   // ---------------------------------------------------------------------------
   // next-state / next-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state;
      r_d         = r;
      c_d         = c;
      pix_d       = pix;
      rd_base_d   = rd_base_q;
      wr_base_d   = wr_base_q;
      res_d       = res_q;
      hreq_d      = hreq;
      haddr_d     = haddr;
      hwrite_d    = hwrite;
      hwdata_d    = hwdata;
      win_valid_d = win_valid;
      res_ready_d = res_ready;
      done_d      = done;
      rd_fire     = 1'b0;
      adv         = 1'b0;
`ifdef BORDER_FILL_EN
      br_d        = br;
      bc_d        = bc;
      bidx_d      = bidx;
`endif

      case (state)
         IDLE: begin
            if (start && !stop) begin
               rd_base_d = rd_base;
               wr_base_d = wr_base;
               r_d       = '0;
               c_d       = '0;
               pix_d     = '0;
               done_d    = 1'b0;
               state_d   = RD_REQ;
            end
         end
         RD_REQ: begin
            hreq_d   = 1'b1;
            hwrite_d = 1'b0;
            haddr_d  = rd_base_q + pix;
            state_d  = RD_WAIT;
         end
         RD_WAIT: begin
            if (hready) begin
               hreq_d  = 1'b0;
               rd_fire = 1'b1;
               if (r >= R_TWO && c >= C_TWO) begin
                  win_valid_d = 1'b1;
                  state_d     = WIN;
               end else begin
                  adv = 1'b1;
               end
            end
         end
         WIN: begin
            if (win_ready) begin
               win_valid_d = 1'b0;
               res_ready_d = 1'b1;
               state_d     = RES;
            end
         end
         RES: begin
            if (res_valid) begin
               res_ready_d = 1'b0;
               res_d       = res_data;
               state_d     = WR_REQ;
            end
         end
         WR_REQ: begin
            hreq_d   = 1'b1;
            hwrite_d = 1'b1;
            haddr_d  = wr_base_q + pix - WR_OFS;
            hwdata_d = 32'(res_q);
            state_d  = WR_WAIT;
         end
         WR_WAIT: begin
            if (hready) begin
               hreq_d = 1'b0;
               adv    = 1'b1;
            end
         end
`ifdef BORDER_FILL_EN
         // issue on hreq low, complete on hready; the idle cycle in between
         // gives the mandatory gap between transactions
         BORDER: begin
            if (!hreq) begin
               hreq_d   = 1'b1;
               hwrite_d = 1'b1;
               haddr_d  = wr_base_q + bidx;
               hwdata_d = 32'(FILL);
            end else if (hready) begin
               hreq_d = 1'b0;
               if (br == R_LAST && bc == C_LAST) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else if (br == '0 || br == R_LAST || bc == C_LAST) begin
                  if (bc == C_LAST) begin
                     bc_d = '0;
                     br_d = br + RW'(1);
                  end else begin
                     bc_d = bc + CW'(1);
                  end
                  bidx_d = bidx + ADDR_W'(1);
               end else begin
                  // interior row: jump from col 0 straight to the last col
                  bc_d   = C_LAST;
                  bidx_d = bidx + W_A - ADDR_W'(1);
               end
            end
         end
`endif
         ABORT: begin
            if (hready) begin
               hreq_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (adv) begin
         pix_d = pix + ADDR_W'(1);
         if (c == C_LAST) begin
            c_d = '0;
            if (r == R_LAST) begin
`ifdef BORDER_FILL_EN
               br_d    = '0;
               bc_d    = '0;
               bidx_d  = '0;
               state_d = BORDER;
`else
               done_d  = 1'b1;
               state_d = IDLE;
`endif
            end else begin
               r_d     = r + RW'(1);
               state_d = RD_REQ;
            end
         end else begin
            c_d     = c + CW'(1);
            state_d = RD_REQ;
         end
      end

      // stop: drop straight to IDLE unless a transaction is still outstanding
      if (stop && state != IDLE && state != ABORT) begin
         hreq_d      = hreq && !hready;
         state_d     = (hreq && !hready) ? ABORT : IDLE;
         win_valid_d = 1'b0;
         res_ready_d = 1'b0;
         done_d      = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   // ---------------------------------------------------------------------------
   // state and registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         r         <= '0;
         c         <= '0;
         pix       <= '0;
         rd_base_q <= '0;
         wr_base_q <= '0;
         res_q     <= '0;
         hreq      <= 1'b0;
         haddr     <= '0;
         hwrite    <= 1'b0;
         hwdata    <= '0;
         win_valid <= 1'b0;
         res_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef BORDER_FILL_EN
         br        <= '0;
         bc        <= '0;
         bidx      <= '0;
`endif
      end else begin
         state     <= state_d;
         r         <= r_d;
         c         <= c_d;
         pix       <= pix_d;
         rd_base_q <= rd_base_d;
         wr_base_q <= wr_base_d;
         res_q     <= res_d;
         hreq      <= hreq_d;
         haddr     <= haddr_d;
         hwrite    <= hwrite_d;
         hwdata    <= hwdata_d;
         win_valid <= win_valid_d;
         res_ready <= res_ready_d;
         busy      <= busy_d;
         done      <= done_d;
`ifdef BORDER_FILL_EN
         br        <= br_d;
         bc        <= bc_d;
         bidx      <= bidx_d;
`endif
      end
   end

   // 3x3 window: columns shift left, the new column is (lb1[c], lb2[c], pixel)
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         win_q <= '0;
      end else if (rd_fire) begin
         win_q[0] <= win_q[1];
         win_q[1] <= win_q[2];
         win_q[2] <= lb1[c];
         win_q[3] <= win_q[4];
         win_q[4] <= win_q[5];
         win_q[5] <= lb2[c];
         win_q[6] <= win_q[7];
         win_q[7] <= win_q[8];
         win_q[8] <= pix_in;
      end
   end

   // line buffers: lb1 holds row r-2, lb2 row r-1; both age by one row per pass
   always_ff @(posedge clk) begin
      if (rd_fire) begin
         lb1[c] <= lb2[c];
         lb2[c] <= pix_in;
      end
   end

endmodule

// File: tb/tb_edge_window_dma.sv
// -----------------------------------------------------------------------------
// tb_edge_window_dma
//   Directed bench for edge_window_dma on a 5x4 frame. A memory model returns
//   pixel = index (address - 0x100). A filter model returns window slot 4.
//   Expected bus transactions are queued before each frame starts and are
//   popped as the DUT completes them.
// -----------------------------------------------------------------------------
module tb_edge_window_dma;
   localparam int W  = 5;
   localparam int H  = 4;
   localparam int PW = 24;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   logic            clk = 1'b0;
   logic            n_rst;
   logic            start, stop;
   logic [31:0]     rd_base, wr_base;
   logic            hreq, hwrite, hready;
   logic [31:0]     haddr, hwdata, hrdata;
   logic            win_valid, win_ready, res_valid, res_ready, busy, done;
   logic [9*PW-1:0] win_data;
   logic [PW-1:0]   res_data;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   lat     = 0;
   int   stall   = 0;
   int   wait_cnt = 0;
   int   wv_cnt   = 0;
   bit   chk_first = 0;
   txn_t q[$];

   edge_window_dma #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW), .ADDR_W(32)) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .stop(stop),
      .rd_base(rd_base), .wr_base(wr_base),
      .hreq(hreq), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata),
      .hrdata(hrdata), .hready(hready),
      .win_valid(win_valid), .win_data(win_data), .win_ready(win_ready),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // slave: completes after lat wait cycles; memory holds pixel = index
   assign hready = hreq && (wait_cnt >= lat);
   assign hrdata = (hreq && !hwrite) ? ((haddr - 32'h100) & 32'h00FF_FFFF) : 32'h0;
   always @(posedge clk) wait_cnt <= (!hreq || hready) ? 0 : wait_cnt + 1;

   // filter: stalls win_ready for 'stall' cycles, returns centre slot
   assign win_ready = win_valid && (wv_cnt >= stall);
   assign res_valid = res_ready;
   assign res_data  = win_data[4*PW +: PW];
   always @(posedge clk) wv_cnt <= (!win_valid || win_ready) ? 0 : wv_cnt + 1;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_hreq"},      256'(hreq),      256'(0));
      chk({tag, "_haddr"},     256'(haddr),     256'(0));
      chk({tag, "_hwrite"},    256'(hwrite),    256'(0));
      chk({tag, "_hwdata"},    256'(hwdata),    256'(0));
      chk({tag, "_win_valid"}, 256'(win_valid), 256'(0));
      chk({tag, "_res_ready"}, 256'(res_ready), 256'(0));
      chk({tag, "_busy"},      256'(busy),      256'(0));
      chk({tag, "_done"},      256'(done),      256'(0));
   endtask

   task automatic push_frame();
      logic [31:0] a;
      q.delete();
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            q.push_back('{1'b0, 32'(32'h100 + r*W + c), 32'h0});
            if (r >= 2 && c >= 2) begin
`ifdef BORDER_FILL_EN
               a = 32'(32'h200 + (r-1)*W + (c-1));
`else
               a = 32'(32'h200 + (r-2)*W + (c-2));
`endif
               q.push_back('{1'b1, a, 32'((r-1)*W + (c-1))});
            end
         end
      end
`ifdef BORDER_FILL_EN
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            if (r == 0 || r == H-1 || c == 0 || c == W-1)
               q.push_back('{1'b1, 32'(32'h200 + r*W + c), 32'h00FF_FFFF});
`endif
   endtask

   // pulse start, then monitor until busy falls or the budget runs out
   task automatic run(input int budget, input bit do_stop, input bit poke_start,
                      output int busy_cyc);
      int              cyc;
      bit              seen_busy, stop_done, prev_hreq, prev_wv;
      logic [31:0]     held_addr;
      logic [9*PW-1:0] held_win;
      txn_t            e;
      cyc = 0; seen_busy = 0; stop_done = 0; prev_hreq = 0; prev_wv = 0;
      busy_cyc = 0; held_addr = '0; held_win = '0;
      @(negedge clk);
      start = 1'b1;
      while (cyc < budget) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         stop  = 1'b0;
         if (busy) begin
            busy_cyc++;
            seen_busy = 1;
         end
         if (hreq) begin
            if (prev_hreq) chk("haddr_stable", 256'(haddr), 256'(held_addr));
            else held_addr = haddr;
            if (do_stop && !stop_done) begin
               stop = 1'b1;
               stop_done = 1;
            end
         end
         prev_hreq = hreq;
         if (win_valid) begin
            if (prev_wv) chk("win_stable", 256'(win_data), 256'(held_win));
            else begin
               held_win = win_data;
               if (chk_first) begin
                  chk("win0_slot0", 256'(win_data[0*PW +: PW]), 256'(0));
                  chk("win0_slot4", 256'(win_data[4*PW +: PW]), 256'(1*W + 1));
                  chk("win0_slot8", 256'(win_data[8*PW +: PW]), 256'(2*W + 2));
                  chk_first = 0;
               end
            end
         end
         prev_wv = win_valid;
         if (hreq && hready) begin
            chk("txn_expected", 256'(q.size() > 0), 256'(1));
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("txn_dir",  256'(hwrite), 256'(e.wr));
               chk("txn_addr", 256'(haddr),  256'(e.addr));
               if (e.wr) chk("txn_wdata", 256'(hwdata), 256'(e.data));
            end
         end
         if (poke_start && cyc == 20) begin
            start   = 1'b1;
            rd_base = 32'h999;
         end
         if (seen_busy && !busy) break;
      end
      chk("frame_ends", 256'(seen_busy && !busy), 256'(1));
      rd_base = 32'h100;
   endtask

   initial begin
      int bc, exp_cyc, hcnt, interior;
      n_rst = 1'b0; start = 1'b0; stop = 1'b0;
      rd_base = 32'h100; wr_base = 32'h200;
      #12;
      chk_reset("reset");
      @(negedge clk);
      n_rst = 1'b1;

      // scenario 1: zero-wait slave, ready filter
      interior = (H-2)*(W-2);
      exp_cyc  = interior*6 + (W*H - interior)*2;
`ifdef BORDER_FILL_EN
      exp_cyc += (2*W + 2*(H-2))*2;
`endif
      lat = 0; stall = 0; chk_first = 1;
      push_frame();
      run(2000, 0, 0, bc);
      chk("s1_done",      256'(done),     256'(1));
      chk("s1_queue",     256'(q.size()), 256'(0));
      chk("s1_busy_cyc",  256'(bc),       256'(exp_cyc));

      // scenario 2: slow slave, stalled filter, ignored start mid-frame
      lat = 3; stall = 5;
      push_frame();
      run(5000, 0, 1, bc);
      chk("s2_done",  256'(done),     256'(1));
      chk("s2_queue", 256'(q.size()), 256'(0));

      // scenario 3: stop during the first read, slave 2 cycles late
      lat = 2; stall = 0;
      q.delete();
      q.push_back('{1'b0, 32'h100, 32'h0});
      run(200, 1, 0, bc);
      chk("stop_queue", 256'(q.size()), 256'(0));
      chk("stop_done",  256'(done),     256'(0));
      hcnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (hreq) hcnt++;
      end
      chk("stop_no_hreq", 256'(hcnt), 256'(0));
      chk("stop_idle",    256'(busy), 256'(0));

      // start together with stop in IDLE stays idle; lone stop is ignored
      @(negedge clk); start = 1'b1; stop = 1'b1;
      @(negedge clk); start = 1'b0; stop = 1'b1;
      @(negedge clk); stop = 1'b0;
      @(negedge clk);
      chk("startstop_busy", 256'(busy), 256'(0));
      chk("startstop_hreq", 256'(hreq), 256'(0));

      // scenario 4: asynchronous reset mid-frame, then a full frame again
      lat = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (30) @(negedge clk);
      chk("midframe_busy", 256'(busy), 256'(1));
      #2 n_rst = 1'b0;
      #1 chk_reset("async_rst");
      @(negedge clk);
      n_rst = 1'b1;
      push_frame();
      run(2000, 0, 0, bc);
      chk("rst_done",  256'(done),     256'(1));
      chk("rst_queue", 256'(q.size()), 256'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
